// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller for the RD53A boundary-scan chain: TAP FSM, instruction
// register, IDCODE/BYPASS data registers, BSC-chain control decode and TDO mux.
module jtag_tap_ctrl #(
  parameter int unsigned IR_WIDTH = 4,
  parameter logic [31:0] IDCODE   = 32'h0000_0001
) (
  input  logic                TCK,
  input  logic                RESET,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                BSC_TDO,
  output logic                TDO,
  output logic                TDO_EN,
  output logic                SHIFT_DR,
  output logic                SHIFT_EN,
  output logic                UPDATE_DR,
  output logic                MODE,
  output logic [3:0]          TAP_STATE,
  output logic [IR_WIDTH-1:0] IR_Q
);

  typedef enum logic [3:0] {
    S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR  = 4'h2, S_PADR  = 4'h3,
    S_SELIR = 4'h4, S_UPDR  = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7,
    S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR  = 4'hA, S_PAIR  = 4'hB,
    S_RTI   = 4'hC, S_UPIR  = 4'hD, S_CAPIR = 4'hE, S_TLR   = 4'hF
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IR_EXTEST  = '0;
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_t          r_state;
  tap_state_t          w_state_nxt;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] w_ir_sr_nxt;
  logic [IR_WIDTH-1:0] r_ir_q;
  logic [31:0]         r_id_sr;
  logic [31:0]         w_id_sr_nxt;
  logic                r_bypass;
  logic                w_bypass_nxt;
  logic                r_tdo;
  logic                r_tdo_en;
  logic                r_tdo_bsc;
  logic                w_tdo_nxt;
  logic                w_sel_bsc;
  logic                w_sel_id;
  logic                w_sel_byp;

  assign w_sel_bsc = (r_ir_q == IR_EXTEST) || (r_ir_q == IR_SAMPLE);
  assign w_sel_id  = (r_ir_q == IR_IDCODE);
  assign w_sel_byp = !(w_sel_bsc || w_sel_id);

  always_comb begin
    w_state_nxt = S_TLR;
    case (r_state)
      S_TLR:   w_state_nxt = TMS ? S_TLR   : S_RTI;
      S_RTI:   w_state_nxt = TMS ? S_SELDR : S_RTI;
      S_SELDR: w_state_nxt = TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: w_state_nxt = TMS ? S_EX1DR : S_SHDR;
      S_SHDR:  w_state_nxt = TMS ? S_EX1DR : S_SHDR;
      S_EX1DR: w_state_nxt = TMS ? S_UPDR  : S_PADR;
      S_PADR:  w_state_nxt = TMS ? S_EX2DR : S_PADR;
      S_EX2DR: w_state_nxt = TMS ? S_UPDR  : S_SHDR;
      S_UPDR:  w_state_nxt = TMS ? S_SELDR : S_RTI;
      S_SELIR: w_state_nxt = TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: w_state_nxt = TMS ? S_EX1IR : S_SHIR;
      S_SHIR:  w_state_nxt = TMS ? S_EX1IR : S_SHIR;
      S_EX1IR: w_state_nxt = TMS ? S_UPIR  : S_PAIR;
      S_PAIR:  w_state_nxt = TMS ? S_EX2IR : S_PAIR;
      S_EX2IR: w_state_nxt = TMS ? S_UPIR  : S_SHIR;
      S_UPIR:  w_state_nxt = TMS ? S_SELDR : S_RTI;
      default: w_state_nxt = S_TLR;
    endcase
  end

  // Only the selected data register captures/shifts; everything holds in pause/exit states.
  always_comb begin
    w_ir_sr_nxt  = r_ir_sr;
    w_id_sr_nxt  = r_id_sr;
    w_bypass_nxt = r_bypass;
    case (r_state)
      S_CAPIR: w_ir_sr_nxt = IR_CAPTURE;
      S_SHIR:  w_ir_sr_nxt = {TDI, r_ir_sr[IR_WIDTH-1:1]};
      S_CAPDR: begin
        if (w_sel_id)  w_id_sr_nxt  = IDCODE;
        if (w_sel_byp) w_bypass_nxt = 1'b0;
      end
      S_SHDR: begin
        if (w_sel_id)  w_id_sr_nxt  = {TDI, r_id_sr[31:1]};
        if (w_sel_byp) w_bypass_nxt = TDI;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_tdo_nxt = 1'b0;
    if (w_state_nxt == S_SHIR) begin
      w_tdo_nxt = w_ir_sr_nxt[0];
    end else if (w_state_nxt == S_SHDR) begin
      if (w_sel_id)       w_tdo_nxt = w_id_sr_nxt[0];
      else if (w_sel_byp) w_tdo_nxt = w_bypass_nxt;
    end
  end

  always_ff @(posedge TCK) begin
    if (RESET) begin
      r_state   <= S_TLR;
      r_ir_sr   <= '0;
      r_ir_q    <= IR_IDCODE;
      r_id_sr   <= IDCODE;
      r_bypass  <= 1'b0;
      r_tdo     <= 1'b0;
      r_tdo_en  <= 1'b0;
      r_tdo_bsc <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ir_sr  <= w_ir_sr_nxt;
      r_id_sr  <= w_id_sr_nxt;
      r_bypass <= w_bypass_nxt;
      if (r_state == S_TLR)       r_ir_q <= IR_IDCODE;
      else if (r_state == S_UPIR) r_ir_q <= r_ir_sr;
      r_tdo     <= w_tdo_nxt;
      r_tdo_en  <= (w_state_nxt == S_SHDR) || (w_state_nxt == S_SHIR);
      r_tdo_bsc <= (w_state_nxt == S_SHDR) && w_sel_bsc;
    end
  end

  // The last BSC scan FF already launches on posedge TCK, so its bit is passed
  // straight through under a registered select instead of being re-registered.
  assign TDO       = r_tdo_bsc ? BSC_TDO : r_tdo;
  assign TDO_EN    = r_tdo_en;
  assign SHIFT_EN  = w_sel_bsc && ((r_state == S_CAPDR) || (r_state == S_SHDR));
  assign SHIFT_DR  = w_sel_bsc && (r_state == S_SHDR);
  assign UPDATE_DR = w_sel_bsc && (r_state == S_UPDR);
  assign MODE      = (r_ir_q == IR_EXTEST);
  assign TAP_STATE = r_state;
  assign IR_Q      = r_ir_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: directed TAP scans over an 8-cell BSC chain model,
// then a random TMS/TDI walk, all checked against a table-driven reference model.
module tb_jtag_tap_ctrl;

  localparam logic [31:0] TB_IDCODE = 32'h4B2D_E0A7;
  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
                         S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PADR = 4'h3, S_EX2DR = 4'h0,
                         S_UPDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
                         S_EX1IR = 4'h9, S_PAIR = 4'hB, S_EX2IR = 4'h8, S_UPIR = 4'hD;

  logic       TCK = 1'b0;
  logic       RESET, TMS, TDI, BSC_TDO;
  logic       TDO, TDO_EN, SHIFT_DR, SHIFT_EN, UPDATE_DR, MODE;
  logic [3:0] TAP_STATE;
  logic [3:0] IR_Q;

  int n_cmp = 0;
  int n_mis = 0;

  jtag_tap_ctrl #(.IR_WIDTH(4), .IDCODE(TB_IDCODE)) dut (
    .TCK(TCK), .RESET(RESET), .TMS(TMS), .TDI(TDI), .BSC_TDO(BSC_TDO),
    .TDO(TDO), .TDO_EN(TDO_EN), .SHIFT_DR(SHIFT_DR), .SHIFT_EN(SHIFT_EN),
    .UPDATE_DR(UPDATE_DR), .MODE(MODE), .TAP_STATE(TAP_STATE), .IR_Q(IR_Q)
  );

  // clock / reset
  always #5 TCK = ~TCK;

  // 8-cell BSC chain: cell 0 drives BSC_TDO, TDI enters cell 7
  logic [7:0] chain_q = 8'h00;
  logic [7:0] upd_q   = 8'h00;
  logic [7:0] ndi     = 8'h00;
  wire  [7:0] ndo     = MODE ? upd_q : ndi;
  assign BSC_TDO = chain_q[0];
  always @(posedge TCK) if (SHIFT_EN) chain_q <= SHIFT_DR ? {TDI, chain_q[7:1]} : ndi;
  always @(negedge TCK) if (UPDATE_DR) upd_q <= chain_q;

  // reference model
  logic [3:0]  nxt0 [16];
  logic [3:0]  nxt1 [16];
  logic [3:0]  m_state = S_TLR;
  logic [3:0]  m_ir = 4'd2;
  logic [3:0]  m_irsr = 4'd0;
  logic [31:0] m_id = TB_IDCODE;
  logic        m_byp = 1'b0;
  logic        m_tdo = 1'b0;
  logic        m_tdo_en = 1'b0;
  int          cnt_shen, cnt_shdr;

  task automatic set_tr(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  task automatic model_step(input bit tms, input bit tdi, input bit rst);
    logic [3:0] s, ns;
    s  = m_state;
    ns = rst ? S_TLR : (tms ? nxt1[s] : nxt0[s]);
    if (rst) begin
      m_irsr = 4'd0; m_ir = 4'd2; m_id = TB_IDCODE; m_byp = 1'b0;
    end else begin
      if (s == S_TLR)   m_ir = 4'd2;
      if (s == S_UPIR)  m_ir = m_irsr;
      if (s == S_CAPIR) m_irsr = 4'd1;
      if (s == S_SHIR)  m_irsr = (m_irsr >> 1) | (4'(tdi) << 3);
      if (s == S_CAPDR) begin m_id = TB_IDCODE; m_byp = 1'b0; end
      if (s == S_SHDR) begin
        if (m_ir == 4'd2)     m_id = (m_id >> 1) | (32'(tdi) << 31);
        else if (m_ir > 4'd1) m_byp = tdi;
      end
    end
    m_state  = ns;
    m_tdo_en = (ns == S_SHDR) || (ns == S_SHIR);
    if (ns == S_SHIR)      m_tdo = m_irsr[0];
    else if (ns == S_SHDR) m_tdo = (m_ir == 4'd2) ? m_id[0] : m_byp;
    else                   m_tdo = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one TCK cycle, then compare every tracked output at the negedge
  task automatic tick(input bit tms, input bit tdi);
    logic bsc;
    logic [3:0] exp_ctrl;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    model_step(tms, tdi, RESET);
    @(negedge TCK);
    bsc = (m_ir <= 4'd1);
    exp_ctrl = {bsc && (m_state == S_CAPDR || m_state == S_SHDR), bsc && (m_state == S_SHDR),
                bsc && (m_state == S_UPDR), m_ir == 4'd0};
    check("tap_state", 32'(TAP_STATE), 32'(m_state));
    check("ir_q", 32'(IR_Q), 32'(m_ir));
    check("tdo_en", 32'(TDO_EN), 32'(m_tdo_en));
    check("tdo", 32'(TDO), 32'((m_state == S_SHDR && bsc) ? BSC_TDO : m_tdo));
    check("bsc_ctrl", 32'({SHIFT_EN, SHIFT_DR, UPDATE_DR, MODE}), 32'(exp_ctrl));
    cnt_shen += int'(SHIFT_EN);
    cnt_shdr += int'(SHIFT_DR);
  endtask

  task automatic ir_scan(input logic [3:0] v, output logic [3:0] cap);
    cap = '0;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = TDO;
      tick(i == 3, v[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, input int pause_at,
                         output logic [31:0] cap);
    cap = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      cap[i] = TDO;
      if (i == pause_at && i != n - 1) begin
        tick(1, din[i]); tick(0, 0); tick(0, 0); tick(0, 0); tick(1, 0); tick(0, 0);
      end else begin
        tick(i == n - 1, din[i]);
      end
    end
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    logic [3:0]  ir_cap;
    logic [31:0] dr_cap, din;
    set_tr(S_TLR, S_RTI, S_TLR);       set_tr(S_RTI, S_RTI, S_SELDR);
    set_tr(S_SELDR, S_CAPDR, S_SELIR); set_tr(S_CAPDR, S_SHDR, S_EX1DR);
    set_tr(S_SHDR, S_SHDR, S_EX1DR);   set_tr(S_EX1DR, S_PADR, S_UPDR);
    set_tr(S_PADR, S_PADR, S_EX2DR);   set_tr(S_EX2DR, S_SHDR, S_UPDR);
    set_tr(S_UPDR, S_RTI, S_SELDR);    set_tr(S_SELIR, S_CAPIR, S_TLR);
    set_tr(S_CAPIR, S_SHIR, S_EX1IR);  set_tr(S_SHIR, S_SHIR, S_EX1IR);
    set_tr(S_EX1IR, S_PAIR, S_UPIR);   set_tr(S_PAIR, S_PAIR, S_EX2IR);
    set_tr(S_EX2IR, S_SHIR, S_UPIR);   set_tr(S_UPIR, S_RTI, S_SELDR);

    // reset state
    RESET = 1'b1; TMS = 1'b1; TDI = 1'b0;
    tick(1, 0);
    check("rst_state", 32'(TAP_STATE), 32'hF);
    check("rst_ir_q", 32'(IR_Q), 32'd2);
    check("rst_outs", 32'({TDO, TDO_EN, SHIFT_DR, SHIFT_EN, UPDATE_DR, MODE}), 32'd0);
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) tick(1, 0);
    check("tms5_state", 32'(TAP_STATE), 32'hF);
    check("tms5_ir_q", 32'(IR_Q), 32'd2);
    check("tms5_ctrl", 32'({SHIFT_DR, SHIFT_EN, UPDATE_DR, MODE}), 32'd0);

    // BYPASS instruction: capture pattern, then 1-cycle delay line
    tick(0, 0);
    ir_scan(4'hF, ir_cap);
    check("byp_ir_cap", 32'(ir_cap), 32'b0001);
    check("byp_ir_q", 32'(IR_Q), 32'hF);
    din = 32'($urandom_range(0, 255));
    dr_scan(8, din, -1, dr_cap);
    check("byp_tdo", dr_cap, {24'd0, din[6:0], 1'b0});

    // IDCODE read straight after reset
    RESET = 1'b1; tick(1, 0); RESET = 1'b0; tick(0, 0);
    cnt_shen = 0;
    dr_scan(32, $urandom, -1, dr_cap);
    check("idcode_tdo", dr_cap, TB_IDCODE);
    check("idcode_shen", 32'(cnt_shen), 32'd0);

    // SAMPLE/PRELOAD with a 3-cycle pause mid-scan
    ndi = 8'hA5;
    ir_scan(4'h1, ir_cap);
    cnt_shen = 0; cnt_shdr = 0;
    dr_scan(8, 32'h3C, 3, dr_cap);
    check("sample_tdo", dr_cap, 32'hA5);
    check("sample_shen_cnt", 32'(cnt_shen), 32'd9);
    check("sample_shdr_cnt", 32'(cnt_shdr), 32'd8);
    check("sample_mode", 32'(MODE), 32'd0);
    check("sample_preload", 32'(upd_q), 32'h3C);
    check("sample_ndo", 32'(ndo), 32'hA5);

    // EXTEST: pins driven from the preload, then updated by the next scan
    ir_scan(4'h0, ir_cap);
    check("extest_ir_cap", 32'(ir_cap), 32'b0001);
    check("extest_mode", 32'(MODE), 32'd1);
    check("extest_ndo_pre", 32'(ndo), 32'h3C);
    din = 32'($urandom_range(0, 255));
    dr_scan(8, din, -1, dr_cap);
    check("extest_tdo", dr_cap, 32'hA5);
    check("extest_ndo_upd", 32'(ndo), din);

    // reset in the middle of an EXTEST shift
    tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1); tick(0, 0);
    RESET = 1'b1; tick(0, 0); RESET = 1'b0;
    check("midrst_state", 32'(TAP_STATE), 32'hF);
    check("midrst_mode", 32'(MODE), 32'd0);
    check("midrst_ir_q", 32'(IR_Q), 32'd2);
    check("midrst_tdo_en", 32'(TDO_EN), 32'd0);

    // random walk
    for (int k = 0; k < 800; k++) begin
      RESET = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 31) == 0) ndi = 8'($urandom);
      tick($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
    end
    RESET = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
